scroll_msg_display: RTL and testbench
=====================================

// Module: scroll_msg_display
// PURPOSE
//  Parametrised successor to the 4-digit selectable "dE1" character display.
//  - Holds a NUM_CHARS-character message of 2-bit glyph codes.
//  - Rotates the message automatically across NUM_DIGITS 7-segment digits
//    on a prescaled tick. Direction is selectable.
//  - Sits between board switches/keys and the HEX outputs of the lab top level.
// PARAMETERS
//  NUM_DIGITS  4           number of 7-seg digits driven (>=1)
//  NUM_CHARS   4           message length in characters (>=2)
//  TICK_DIV    50_000_000  clk cycles per rotation step (>=2; use 4 in sim)
//  PAUSE_TICKS 2           extra ticks held at pos 0 (WRAP_PAUSE_EN only, >=1)
// PORTS
//  clk      in   1                       system clock
//  resetn   in   1                       synchronous active-low reset
//  en       in   1                       1 = prescaler runs; 0 = freeze all counters
//  dir      in   1                       0 = pos increments; 1 = pos decrements
//  load     in   1                       1-cycle strobe: capture msg_in, restart
//  msg_in   in   NUM_CHARS*2             char j = msg_in[2j+1:2j]
//  hex_out  out  NUM_DIGITS*7            digit k = hex_out[7k+6:7k], active-low gfedcba
//  pos      out  $clog2(NUM_CHARS)       current rotation offset
//  tick     out  1                       1-cycle pulse on each rotation step
// BEHAVIOUR
//  - Clock and reset: one clock domain (clk). Reset is synchronous and
//    active-low (resetn). Everything below is evaluated on rising clk.
//  - Glyph codes (active-low gfedcba):
//      00 = 'd' 7'b0100001
//      01 = 'E' 7'b0000110
//      10 = '1' 7'b1111001
//      11 = blank 7'b1111111
//  - Reset (resetn=0 at a clk edge):
//      msg_reg = all 2'b11; pos = 0; prescaler = 0; tick = 0;
//      hex_out = all 1s (blank); pause counter = 0.
//    Reset overrides load and tick in the same cycle.
//  - Prescaler:
//      - While en=1, it counts 0..TICK_DIV-1 and then wraps.
//      - tick is registered. It is 1 for exactly the cycle after the wrap.
//      - While en=0, the prescaler holds and tick = 0.
//  - Step: on a cycle where the prescaler wraps, pos advances.
//      dir=0: pos = (pos+1) mod NUM_CHARS. From NUM_CHARS-1 it goes to 0.
//      dir=1: pos = (pos-1) mod NUM_CHARS. From 0 it goes to NUM_CHARS-1.
//      Use explicit compare, not bit overflow, since NUM_CHARS need not be 2^n.
//  - load=1:
//      msg_reg = msg_in; pos = 0; prescaler = 0; tick = 0; pause counter = 0.
//      load takes priority over a coincident wrap (no step that cycle).
//      load acts regardless of en.
//  - Mapping: digit k shows msg_reg char (pos+k) mod NUM_CHARS. k=0 is the
//    leftmost digit at the low bits. With NUM_DIGITS > NUM_CHARS the message
//    repeats.
//  - Latency: hex_out is registered and reflects pos/msg_reg one cycle after
//    they change. After load, the new message is visible on cycle 2.
//  - dir may change at any time. It takes effect at the next step only.
// CONFIGURATION
//  - WRAP_PAUSE_EN defined:
//      - When a step lands on pos == 0, the next PAUSE_TICKS ticks are
//        swallowed: tick still pulses, but pos holds.
//      - A load or reset clears the pause.
//  - WRAP_PAUSE_EN undefined: every tick steps pos. No pause logic is
//    synthesised.
// TESTING (TICK_DIV=4, NUM_DIGITS=4, NUM_CHARS=4 unless noted)
//  1. Reset: resetn=0 for 2 clk
//     -> hex_out=28'hFFFFFFF, pos=0, tick=0.
//  2. load msg_in=8'b11_10_01_00, en=0
//     -> 2 clk later digit0..3 = d,E,1,blank; pos stays 0 indefinitely.
//  3. en=1, dir=0: tick every 4 clk
//     -> pos sequence 1,2,3,0; after the first step digit0..3 = E,1,blank,d.
//  4. en=1, dir=1 from pos=0
//     -> next pos=3; digit0 = blank; then pos 2,1,0.
//  5. load asserted on the same cycle as the prescaler wrap
//     -> pos=0, prescaler=0, no step; next tick occurs 4 clk later.
//  6. NUM_CHARS=3, NUM_DIGITS=5, msg d,E,1
//     -> digits d,E,1,d,E; pos wraps 2->0.
//     With WRAP_PAUSE_EN: pos holds at 0 for 2 extra ticks.

Source files
------------

// File: rtl/scroll_msg_display.sv
// Rotating NUM_CHARS-glyph message shown on NUM_DIGITS active-low 7-segment digits.
// Optional feature macro: WRAP_PAUSE_EN (hold at position 0 for PAUSE_TICKS extra ticks).
module scroll_msg_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_CHARS   = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int PAUSE_TICKS = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         en,
    input  logic                         dir,
    input  logic                         load,
    input  logic [NUM_CHARS*2-1:0]       msg_in,
    output logic [NUM_DIGITS*7-1:0]      hex_out,
    output logic [$clog2(NUM_CHARS)-1:0] pos,
    output logic                         tick
);

    localparam int unsigned PW   = $clog2(NUM_CHARS);
    localparam int unsigned CW   = $clog2(TICK_DIV);
    localparam int unsigned NC_U = NUM_CHARS;
    localparam logic [PW-1:0] POS_LAST  = PW'(NUM_CHARS - 1);
    localparam logic [CW-1:0] PRESC_TOP = CW'(TICK_DIV - 1);

    logic [NUM_CHARS*2-1:0]  msg_reg;
    logic [CW-1:0]           prescale;
    logic                    wrap;
    logic                    step;
    logic [PW-1:0]           pos_next;
    logic [1:0]              chars [NUM_CHARS];
    logic [PW-1:0]           idx;
    logic [NUM_DIGITS*7-1:0] hex_next;

    function automatic logic [6:0] glyph(input logic [1:0] code);
        case (code)
            2'b00:   glyph = 7'b0100001;
            2'b01:   glyph = 7'b0000110;
            2'b10:   glyph = 7'b1111001;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign wrap = en && (prescale == PRESC_TOP);

    // Explicit compares so non-power-of-two message lengths wrap correctly.
    always_comb begin
        pos_next = pos;
        if (dir) begin
            pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
        end else begin
            pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
        end
    end

`ifdef WRAP_PAUSE_EN
    localparam int unsigned PCW = $clog2(PAUSE_TICKS + 1);
    localparam logic [PCW-1:0] PAUSE_VAL = PCW'(PAUSE_TICKS);

    logic [PCW-1:0] pause_cnt;

    // A step that lands on 0 arms the pause; each later tick burns one count.
    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            pause_cnt <= '0;
        end else if (wrap) begin
            if (pause_cnt != '0) begin
                pause_cnt <= pause_cnt - 1'b1;
            end else if (pos_next == '0) begin
                pause_cnt <= PAUSE_VAL;
            end
        end
    end

    always_comb step = (pause_cnt == '0);
`else
    always_comb step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            msg_reg  <= '1;
            pos      <= '0;
            prescale <= '0;
            tick     <= 1'b0;
        end else if (load) begin
            msg_reg  <= msg_in;
            pos      <= '0;
            prescale <= '0;
            tick     <= 1'b0;
        end else if (wrap) begin
            prescale <= '0;
            tick     <= 1'b1;
            if (step) begin
                pos <= pos_next;
            end
        end else if (en) begin
            prescale <= prescale + 1'b1;
            tick     <= 1'b0;
        end else begin
            tick     <= 1'b0;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NUM_CHARS; j++) begin
            chars[j] = msg_reg[2*j +: 2];
        end
    end

    always_comb begin
        hex_next = '1;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx = PW'((32'(pos) + k) % NC_U);
            hex_next[7*k +: 7] = glyph(chars[idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hex_out <= '1;
        end else begin
            hex_out <= hex_next;
        end
    end

endmodule

// File: tb/tb_scroll_msg_display.sv
// Bench for scroll_msg_display: two configurations (4x4 and 3 chars on 5 digits)
// driven in lockstep and compared each cycle against a cycle-level arithmetic model.
module tb_scroll_msg_display;

    localparam int TD = 4;
    localparam int PT = 2;

    logic        clk = 1'b0;
    logic        resetn, en, dir, load;
    logic [7:0]  msg_a;
    logic [5:0]  msg_b;
    logic [27:0] hex_a;
    logic [34:0] hex_b;
    logic [1:0]  pos_a, pos_b;
    logic        tick_a, tick_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scroll_msg_display #(.NUM_DIGITS(4), .NUM_CHARS(4), .TICK_DIV(TD), .PAUSE_TICKS(PT)) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .dir(dir), .load(load),
        .msg_in(msg_a), .hex_out(hex_a), .pos(pos_a), .tick(tick_a)
    );

    scroll_msg_display #(.NUM_DIGITS(5), .NUM_CHARS(3), .TICK_DIV(TD), .PAUSE_TICKS(PT)) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .dir(dir), .load(load),
        .msg_in(msg_b), .hex_out(hex_b), .pos(pos_b), .tick(tick_b)
    );

    // Reference model state, unit 0 = dut_a, unit 1 = dut_b
    int          nc [2] = '{4, 3};
    int          nd [2] = '{4, 5};
    int          m_msg [2][4];
    int          m_pos [2];
    int          m_cnt [2];
    int          m_tick [2];
    int          m_pause [2];
    logic [34:0] m_hex [2];
    logic [6:0]  seg [4] = '{7'b0100001, 7'b0000110, 7'b1111001, 7'b1111111};
    bit          pause_en;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int u);
        logic [34:0] h;
        h = '0;
        for (int k = 0; k < nd[u]; k++) begin
            if (!resetn) h[7*k +: 7] = 7'h7F;
            else         h[7*k +: 7] = seg[m_msg[u][(m_pos[u] + k) % nc[u]]];
        end
        m_hex[u] = h;
        if (!resetn || load) begin
            for (int j = 0; j < nc[u]; j++) begin
                if (!resetn)     m_msg[u][j] = 3;
                else if (u == 0) m_msg[u][j] = int'(msg_a[2*j +: 2]);
                else             m_msg[u][j] = int'(msg_b[2*j +: 2]);
            end
            m_pos[u] = 0; m_cnt[u] = 0; m_tick[u] = 0; m_pause[u] = 0;
        end else if (en) begin
            if (m_cnt[u] == TD - 1) begin
                m_cnt[u]  = 0;
                m_tick[u] = 1;
                if (m_pause[u] > 0) begin
                    m_pause[u]--;
                end else begin
                    m_pos[u] = dir ? (m_pos[u] + nc[u] - 1) % nc[u] : (m_pos[u] + 1) % nc[u];
                    if (pause_en && m_pos[u] == 0) m_pause[u] = PT;
                end
            end else begin
                m_cnt[u]++;
                m_tick[u] = 0;
            end
        end else begin
            m_tick[u] = 0;
        end
    endtask

    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("hex_a",  {7'b0, hex_a},  m_hex[0]);
        chk("pos_a",  35'(pos_a),     35'(m_pos[0]));
        chk("tick_a", 35'(tick_a),    35'(m_tick[0]));
        chk("hex_b",  hex_b,          m_hex[1]);
        chk("pos_b",  35'(pos_b),     35'(m_pos[1]));
        chk("tick_b", 35'(tick_b),    35'(m_tick[1]));
    endtask

    initial begin
        int gap;
`ifdef WRAP_PAUSE_EN
        pause_en = 1'b1;
`else
        pause_en = 1'b0;
`endif
        for (int u = 0; u < 2; u++) begin
            m_pos[u] = 0; m_cnt[u] = 0; m_tick[u] = 0; m_pause[u] = 0; m_hex[u] = '0;
            for (int j = 0; j < 4; j++) m_msg[u][j] = 3;
        end
        resetn = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
        msg_a = '0; msg_b = '0;

        // Reset for two clocks
        cycle();
        cycle();
        chk("reset_hex_a", {7'b0, hex_a}, {7'b0, 28'hFFFFFFF});

        // Load d,E,1,blank with en=0; position must stay put
        resetn = 1'b1;
        msg_a = 8'b11_10_01_00;
        msg_b = 6'b10_01_00;
        load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("load_hex_a", {7'b0, hex_a}, {7'b0, 7'h7F, 7'h79, 7'h06, 7'h21});
        chk("load_hex_b", hex_b, {7'h06, 7'h21, 7'h79, 7'h06, 7'h21});
        repeat (8) cycle();
        chk("idle_pos_a", 35'(pos_a), 35'd0);

        // Forward rotation: first tick after exactly 4 enabled clocks
        en = 1'b1;
        gap = 0;
        for (int i = 0; i < 10 && !tick_a; i++) begin
            cycle();
            gap++;
        end
        chk("first_tick_gap", 35'(gap), 35'd4);
        chk("first_step_pos", 35'(pos_a), 35'd1);
        cycle();
        chk("first_step_hex_a", {7'b0, hex_a}, {7'b0, 7'h21, 7'h7F, 7'h79, 7'h06});
        repeat (14) cycle();

        // Reverse rotation
        dir = 1'b1;
        repeat (20) cycle();

        // Load coincident with prescaler wrap: no step, next tick 4 clocks later
        for (int i = 0; i < 10 && m_cnt[0] != TD - 1; i++) cycle();
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_wrap_pos", 35'(pos_a), 35'd0);
        chk("load_wrap_tick", 35'(tick_a), 35'd0);
        gap = 0;
        for (int i = 0; i < 10 && !tick_a; i++) begin
            cycle();
            gap++;
        end
        chk("load_wrap_gap", 35'(gap), 35'd4);

        // Forward run on the 3-char unit to exercise 2->0 wrap
        dir = 1'b0;
        repeat (30) cycle();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            load   = ($urandom_range(0, 24) == 0);
            en     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            msg_a  = 8'($urandom);
            msg_b  = 6'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
